// File: rtl/key_schedule.sv
// Iterative AES-128 key expansion: accepts a cipher key, streams round keys 0..10 with their index.
// Define KEY_SCHED_STORE_EN to build an 11x128 round-key file with registered readback on rd_idx/rd_key.
module key_schedule (
  input  logic         CLK,
  input  logic         RST,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_key,
  output logic [3:0]   rk_idx,
  output logic         done,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);
  localparam int unsigned KW = 128;
  localparam int unsigned IW = 4;
  localparam int unsigned NK = 11;
  localparam logic [IW-1:0] LAST_IDX = 4'd10;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic {IDLE, EMIT} state_e;

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    logic [10:0] base;
    base = {8'(8'hff - b), 3'b000};
    return SBOX[base +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [IW-1:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_e        state_q, state_d;
  logic [KW-1:0] key_q, key_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          done_q, done_d;
  logic [KW-1:0] next_key_c;

  // Next round key from the current one; round number is idx_q + 1.
  always_comb begin
    logic [31:0] rot, t, n0, n1, n2, n3;
    rot = {key_q[23:0], key_q[31:24]};
    t   = {sub_byte(rot[31:24]), sub_byte(rot[23:16]), sub_byte(rot[15:8]), sub_byte(rot[7:0])}
          ^ {rcon(idx_q + 4'd1), 24'h000000};
    n0  = key_q[127:96] ^ t;
    n1  = key_q[95:64]  ^ n0;
    n2  = key_q[63:32]  ^ n1;
    n3  = key_q[31:0]   ^ n2;
    next_key_c = {n0, n1, n2, n3};
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          key_d   = key;
          idx_d   = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            key_d = next_key_c;
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign key_ready = (state_q == IDLE);
  assign rk_valid  = (state_q == EMIT);
  assign rk_key    = key_q;
  assign rk_idx    = idx_q;
  assign done      = done_q;

`ifdef KEY_SCHED_STORE_EN
  logic [KW-1:0] file_q [NK];
  logic [KW-1:0] rd_key_q, rd_key_d;
  logic          wr_en_c;

  assign wr_en_c = (state_q == EMIT) && rk_ready;

  always_comb begin
    rd_key_d = '0;
    if (rd_idx <= LAST_IDX) rd_key_d = file_q[rd_idx];
  end

  // Read sees pre-write contents when the same entry is written this cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NK; i++) file_q[i] <= '0;
      rd_key_q <= '0;
    end else begin
      if (wr_en_c) file_q[idx_q] <= key_q;
      rd_key_q <= rd_key_d;
    end
  end

  assign rd_key = rd_key_q;
`else
  logic unused_rd_idx;
  assign unused_rd_idx = ^rd_idx;
  assign rd_key        = '0;
`endif

endmodule

// File: tb/tb_key_schedule.sv
// Scoreboard bench for key_schedule; reference schedule built from GF(2^8) arithmetic.
`timescale 1ns/1ps
module tb_key_schedule;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic [127:0] key = '0;
  logic         rk_valid;
  logic         rk_ready = 1'b0;
  logic [127:0] rk_key;
  logic [3:0]   rk_idx;
  logic         done;
  logic [3:0]   rd_idx = '0;
  logic [127:0] rd_key;

  key_schedule dut (
    .CLK(CLK), .RST(RST), .key_valid(key_valid), .key_ready(key_ready), .key(key),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_key(rk_key), .rk_idx(rk_idx),
    .done(done), .rd_idx(rd_idx), .rd_key(rd_key)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] key;
  } rk_t;

  rk_t          exp_q[$];
  logic [127:0] file_m [0:10];
  logic [127:0] hold_key = '0;
  logic [3:0]   hold_idx = '0;
  logic [127:0] exp_rd = '0;
  logic         pend_done = 1'b0;
  logic         rand_ready = 1'b0;
  logic         rand_rd = 1'b1;
  int           n_checks = 0;
  int           n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [7:0] r;
    r = (x << n) | (x >> (8 - n));
    return r;
  endfunction

  // S-box from its definition: multiplicative inverse (a^254) then the affine map.
  function automatic logic [7:0] sbox_m(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    if (a == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  // Textbook 44-word expansion; known-answer constants override the model where published.
  task automatic push_schedule(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rk_t         e;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox_m(t[31:24]), sbox_m(t[23:16]), sbox_m(t[15:8]), sbox_m(t[7:0])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) begin
      e.idx = 4'(r);
      e.key = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      if (k == FIPS_KEY && r == 1)  e.key = FIPS_R1;
      if (k == FIPS_KEY && r == 10) e.key = FIPS_R10;
      if (k == '0 && r == 1)        e.key = ZERO_R1;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: outputs are compared on the falling edge against the expected queue.
  always @(negedge CLK) begin : monitor
    logic idle;
    rk_t  front;
    idle = (exp_q.size() == 0);
    if (RST) begin
      exp_q.delete();
      pend_done = 1'b0;
      hold_key  = '0;
      hold_idx  = '0;
      exp_rd    = '0;
      for (int i = 0; i < 11; i++) file_m[i] = '0;
    end else begin
      check("done", 128'(done), 128'(pend_done));
      check("key_ready", 128'(key_ready), 128'(idle));
      check("rk_valid", 128'(rk_valid), 128'(!idle));
      if (!idle) begin
        front = exp_q[0];
        check("rk_key", rk_key, front.key);
        check("rk_idx", 128'(rk_idx), 128'(front.idx));
      end else begin
        check("hold_key", rk_key, hold_key);
        check("hold_idx", 128'(rk_idx), 128'(hold_idx));
      end
      check("rd_key", rd_key, exp_rd);
      exp_rd = '0;
`ifdef KEY_SCHED_STORE_EN
      if (rd_idx <= 4'd10) exp_rd = file_m[rd_idx];
`endif
      pend_done = 1'b0;
      if (!idle && rk_ready) begin
        front = exp_q.pop_front();
        file_m[front.idx] = front.key;
        if (front.idx == 4'd10) begin
          pend_done = 1'b1;
          hold_key  = front.key;
          hold_idx  = front.idx;
        end
      end
      if (idle && key_valid) push_schedule(key);
    end
  end

  always @(posedge CLK) begin
    #1;
    if (rand_ready) rk_ready = 1'($urandom_range(0, 1));
    if (rand_rd) rd_idx = 4'($urandom_range(0, 15));
  end

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic load_key(input logic [127:0] k, input logic keep);
    logic ok;
    @(posedge CLK); #1;
    key_valid = 1'b1;
    key = k;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (key_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("load_timeout", 128'(ok), 128'(1));
    @(posedge CLK); #1;
    if (!keep) key_valid = 1'b0;
    key = rand_key();
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge CLK);
      if (key_ready && !rk_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_timeout", 128'(ok), 128'(1));
  endtask

  initial begin : driver
    logic ok;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    repeat (2) @(posedge CLK);

    // Known-answer schedule at full rate, then fixed readback indices.
    rk_ready = 1'b1;
    load_key(FIPS_KEY, 1'b0);
    wait_idle();
    @(posedge CLK); #1;
    rand_rd = 1'b0;
    rd_idx  = 4'd1;
    repeat (2) @(posedge CLK);
    #1 rd_idx = 4'd12;
    repeat (2) @(posedge CLK);
    #1 rd_idx = 4'd10;
    repeat (2) @(posedge CLK);
    #1 rand_rd = 1'b1;

    // Same key under random back-pressure.
    rand_ready = 1'b1;
    load_key(FIPS_KEY, 1'b0);
    wait_idle();

    // key_valid held high across consecutive schedules.
    rand_ready = 1'b0;
    rk_ready   = 1'b1;
    load_key(rand_key(), 1'b1);
    load_key(rand_key(), 1'b1);
    rand_ready = 1'b1;
    load_key(rand_key(), 1'b0);
    wait_idle();

    // Reset while round key 5 is being presented, then the all-zero key.
    rand_ready = 1'b0;
    @(posedge CLK); #1 rk_ready = 1'b1;
    load_key(rand_key(), 1'b0);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge CLK);
      if (rk_valid && rk_idx == 4'd4) begin
        ok = 1'b1;
        break;
      end
    end
    check("idx4_timeout", 128'(ok), 128'(1));
    @(posedge CLK); #1 RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    repeat (2) @(posedge CLK);
    load_key('0, 1'b0);
    wait_idle();

    // Random keys with random back-pressure and readback.
    rand_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      load_key(rand_key(), 1'b0);
      wait_idle();
    end
    repeat (4) @(posedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
